// File: rtl/rv_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv_muldiv_pkg
// Brief   : RV32M funct3/funct7 codes, FSM encoding, operand sign helper.
// Revision: 1.0
// ============================================================================
package rv_muldiv_pkg;

  localparam logic [2:0] c_F3_MUL    = 3'b000;
  localparam logic [2:0] c_F3_MULH   = 3'b001;
  localparam logic [2:0] c_F3_MULHSU = 3'b010;
  localparam logic [2:0] c_F3_MULHU  = 3'b011;
  localparam logic [2:0] c_F3_DIV    = 3'b100;
  localparam logic [2:0] c_F3_DIVU   = 3'b101;
  localparam logic [2:0] c_F3_REM    = 3'b110;
  localparam logic [2:0] c_F3_REMU   = 3'b111;

  localparam logic [6:0] c_FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // {rs1 is signed, rs2 is signed} for each M-op
  function automatic logic [1:0] op_signs(input logic [2:0] f3);
    logic [1:0] s;
    s = 2'b00;
    case (f3)
      c_F3_MUL:    s = 2'b00;
      c_F3_MULH:   s = 2'b11;
      c_F3_MULHSU: s = 2'b10;
      c_F3_MULHU:  s = 2'b00;
      c_F3_DIV:    s = 2'b11;
      c_F3_DIVU:   s = 2'b00;
      c_F3_REM:    s = 2'b11;
      c_F3_REMU:   s = 2'b00;
      default:     s = 2'b00;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module  : rv_muldiv_step
// Brief   : One radix-2 iteration: shift-add multiply or restoring divide.
// Revision: 1.0
// ============================================================================
module rv_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  input  logic              i_div,
  output logic [2*XLEN-1:0] o_acc,
  output logic              o_qbit
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;

  // Multiply: acc = {partial product, remaining multiplier bits}, consumed LSB first
  assign w_sum     = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
  // Divide: acc = {remainder, dividend bits being shifted in / quotient bits}
  assign w_shifted = i_acc[2*XLEN-1:XLEN-1];
  assign w_diff    = w_shifted - {1'b0, i_opnd};

  always_comb begin
    o_acc  = '0;
    o_qbit = 1'b0;
    if (i_div) begin
      o_qbit = ~w_diff[XLEN];
      o_acc  = {(o_qbit ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0]),
                i_acc[XLEN-2:0], 1'b0};
    end else begin
      o_acc  = {w_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : rv_muldiv
// Brief   : Iterative RV32M multiply/divide unit, fixed 33-cycle latency.
// Revision: 1.0
// ============================================================================
module rv_muldiv
  import rv_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int            c_CW   = $clog2(XLEN) + 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(XLEN - 1);

  state_t              r_state;
  logic [c_CW-1:0]     r_count;
  logic [2:0]          r_f3;
  logic                r_sa;
  logic                r_sb;
  logic                r_bzero;
  logic [XLEN-1:0]     r_opnd;
  logic [2*XLEN-1:0]   r_acc;
  logic                r_busy;
  logic                r_done;
  logic [XLEN-1:0]     r_result;

  logic [1:0]          w_signs;
  logic                w_sa;
  logic                w_sb;
  logic [XLEN-1:0]     w_mag_a;
  logic [XLEN-1:0]     w_mag_b;
  logic [2*XLEN-1:0]   w_step_acc;
  logic                w_qbit;
  logic [2*XLEN-1:0]   w_next_acc;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_final;

  assign w_signs = op_signs(funct3);
  assign w_sa    = w_signs[1] & A[XLEN-1];
  assign w_sb    = w_signs[0] & B[XLEN-1];
  // -0x80000000 wraps to itself, which is exactly the unsigned magnitude 2^31
  assign w_mag_a = w_sa ? -A : A;
  assign w_mag_b = w_sb ? -B : B;

  rv_muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .i_div  (r_f3[2]),
    .o_acc  (w_step_acc),
    .o_qbit (w_qbit)
  );

  assign w_next_acc = {w_step_acc[2*XLEN-1:1], w_step_acc[0] | w_qbit};

  assign w_prod = (r_sa ^ r_sb) ? -w_next_acc : w_next_acc;
  assign w_quo  = ((r_sa ^ r_sb) && !r_bzero) ? -w_next_acc[XLEN-1:0]
                                              : w_next_acc[XLEN-1:0];
  assign w_rem  = r_sa ? -w_next_acc[2*XLEN-1:XLEN] : w_next_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_final = '0;
    if (r_f3[2]) begin
      w_final = r_f3[1] ? w_rem : w_quo;
    end else if (r_f3 == c_F3_MUL) begin
      w_final = w_prod[XLEN-1:0];
    end else begin
      w_final = w_prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_f3     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_bzero  <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_count <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
              r_count <= '0;
              r_f3    <= funct3;
              r_sa    <= w_sa;
              r_sb    <= w_sb;
              r_bzero <= (B == '0);
              if (funct3[2]) begin
                r_opnd <= w_mag_b;
                r_acc  <= {{XLEN{1'b0}}, w_mag_a};
              end else begin
                r_opnd <= w_mag_a;
                r_acc  <= {{XLEN{1'b0}}, w_mag_b};
              end
            end
          end
          S_CALC: begin
            r_acc   <= w_next_acc;
            r_count <= r_count + 1'b1;
            if (r_count == c_LAST) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_final;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_rv_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv_muldiv
// Brief   : Table-driven scoreboard bench for rv_muldiv plus abort sequences.
// Revision: 1.0
// ============================================================================
module tb_rv_muldiv;
  import rv_muldiv_pkg::*;

  localparam int c_PER = 10;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        start  = 1'b0;
  logic        flush  = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] A      = '0;
  logic [31:0] B      = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    time         t_acc;
    string       name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  sb_t  m_e;
  logic prev_done = 1'b0;

  always #(c_PER/2) clk = ~clk;

  rv_muldiv #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .A      (A),
    .B      (B),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest outstanding op
  always @(negedge clk) begin
    if (prev_done) check1("done_width", done, 1'b0);
    prev_done = done;
    if (rst && done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: done=1 with no op outstanding, result=%08h", result);
      end else begin
        m_e = sbq.pop_front();
        check32({m_e.name, "_result"}, result, m_e.exp);
        checks++;
        if (($time - m_e.t_acc) != time'(32*c_PER + c_PER/2)) begin
          errors++;
          $display("FAIL %s_latency: got %0t expected %0t", m_e.name,
                   $time - m_e.t_acc, time'(32*c_PER + c_PER/2));
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name, input bit hold,
                       output time t_done);
    int  n;
    bit  busy_ok;
    sb_t e;
    wait_idle();
    funct3 = f;
    A      = a;
    B      = b;
    start  = 1'b1;
    @(posedge clk);
    e.exp   = exp;
    e.t_acc = $time;
    e.name  = name;
    sbq.push_back(e);
    @(negedge clk);
    if (!hold) start = 1'b0;
    busy_ok = 1'b1;
    n = 0;
    while (!done && n < 60) begin
      if (!busy) busy_ok = 1'b0;
      funct3 = 3'($urandom);
      A      = $urandom;
      B      = $urandom;
      @(negedge clk);
      n++;
    end
    t_done = $time;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, n);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end else begin
      if (!busy) busy_ok = 1'b0;
      check1({name, "_busy_held"}, busy_ok, 1'b1);
    end
    @(negedge clk);
    check1({name, "_busy_after"}, busy, 1'b0);
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check1(name, seen, 1'b0);
  endtask

  initial begin
    #(200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    time         t0;
    time         t1;
    logic [31:0] last_res;

    vecs.push_back('{c_F3_MUL,    32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, "mul_7_m6"});
    vecs.push_back('{c_F3_MULH,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, "mulh_min_m1"});
    vecs.push_back('{c_F3_MULHU,  32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, "mulhu_min_m1"});
    vecs.push_back('{c_F3_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "mulhsu_min_m1"});
    vecs.push_back('{c_F3_MUL,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, "mul_min_m1"});
    vecs.push_back('{c_F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_m1_m1"});
    vecs.push_back('{c_F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1_m1"});
    vecs.push_back('{c_F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1_m1"});
    vecs.push_back('{c_F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_m7_2"});
    vecs.push_back('{c_F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_m7_2"});
    vecs.push_back('{c_F3_DIVU,   32'd20,       32'd3,        32'd6,        "divu_20_3"});
    vecs.push_back('{c_F3_REMU,   32'd20,       32'd3,        32'd2,        "remu_20_3"});
    vecs.push_back('{c_F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, "div_7_m2"});
    vecs.push_back('{c_F3_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        "rem_7_m2"});
    vecs.push_back('{c_F3_DIV,    32'h12345678, 32'd0,        32'hFFFFFFFF, "div_by0"});
    vecs.push_back('{c_F3_REMU,   32'h12345678, 32'd0,        32'h12345678, "remu_by0"});
    vecs.push_back('{c_F3_REM,    32'h87654321, 32'd0,        32'h87654321, "rem_neg_by0"});
    vecs.push_back('{c_F3_DIVU,   32'h87654321, 32'd0,        32'hFFFFFFFF, "divu_by0"});
    vecs.push_back('{c_F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf"});
    vecs.push_back('{c_F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf"});
    vecs.push_back('{c_F3_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, "divu_max_1"});

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check32("reset_result", result, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, 1'b0, t0);
    end
    last_res = vecs[vecs.size()-1].exp;

    // flush after 10 CALC cycles: abort, no done, result retained
    wait_idle();
    funct3 = c_F3_MUL; A = 32'd3; B = 32'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check1("flush_busy", busy, 1'b0);
    check1("flush_done", done, 1'b0);
    check32("flush_result_kept", result, last_res);
    watch_no_done("flush_no_done", 40);

    // flush in IDLE blocks a simultaneous start
    funct3 = c_F3_MUL; A = 32'd3; B = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check1("idle_flush_blocks_start", busy, 1'b0);
    start = 1'b0; flush = 1'b0;

    // asynchronous reset mid-CALC
    funct3 = c_F3_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check1("async_rst_busy", busy, 1'b0);
    check32("async_rst_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    watch_no_done("rst_no_done", 40);
    issue(c_F3_MUL, 32'd3, 32'd5, 32'd15, "mul_after_rst", 1'b0, t0);

    // start held high: ops every 34 cycles, in-flight operands scrambled
    issue(c_F3_DIVU, 32'd1000, 32'd10,     32'd100,      "hold_divu", 1'b1, t0);
    issue(c_F3_MULH, 32'hFFFFFFFF, 32'd2,  32'hFFFFFFFF, "hold_mulh", 1'b1, t1);
    check32("hold_spacing_1", 32'(t1 - t0), 32'(34*c_PER));
    t0 = t1;
    issue(c_F3_REM,  32'hFFFFFF9C, 32'd7,  32'hFFFFFFFE, "hold_rem",  1'b1, t1);
    check32("hold_spacing_2", 32'(t1 - t0), 32'(34*c_PER));
    start = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding expected 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
